// File: rtl/display_pkg.sv
// Shared types, widths and helpers for the 4-digit multiplexed display scanner.
package display_pkg;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned DATA_W   = DIGITS * NIBBLE_W;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        OFF,
        ON,
        GAP
    } state_t;

    // Common-select pattern for the digit at idx.
    function automatic logic [DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    // Index of the most significant nonzero nibble; 0 when the whole value is zero.
    function automatic logic [IDX_W-1:0] top_nonzero_digit(input logic [DATA_W-1:0] v);
        logic [IDX_W-1:0] top;
        top = '0;
        for (int i = 1; i < int'(DIGITS); i++) begin
            if (v[i*NIBBLE_W +: NIBBLE_W] != '0) top = IDX_W'(i);
        end
        return top;
    endfunction

endpackage

// File: rtl/display_scan_4digit_if.sv
// Valid/ready value-load channel into the display scanner.
interface display_scan_4digit_if;
    import display_pkg::*;

    logic              value_valid;
    logic [DATA_W-1:0] value_data;
    logic              value_ready;

    modport master (output value_valid, output value_data, input value_ready);
    modport slave  (input value_valid, input value_data, output value_ready);
endinterface

// File: rtl/display_tick_gen.sv
// Per-digit ON-time prescaler: counts up while not cleared, flags PRESCALE-1.
module display_tick_gen
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else            count <= count + CNT_W'(1);
    end

    assign tc_c = (count == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/display_scan_4digit.sv
// Four-digit multiplexed display scanner with a pending/display double buffer.
// Optional leading-zero blanking: define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scan_4digit
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en,
    display_scan_4digit_if.slave  value,
    output logic [NIBBLE_W-1:0]   digit_nibble,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  digit_blank
);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    index, index_nxt;
    logic [DATA_W-1:0]   pending_data, pending_data_nxt;
    logic [DATA_W-1:0]   display_reg, display_nxt;
    logic                pending_full, pending_full_nxt;
    logic [DIGITS-1:0]   digit_en_nxt;
    logic [NIBBLE_W-1:0] digit_nibble_nxt;
    logic                tc_c;
    logic                cnt_clr_c;
    logic                xfer_c;
    logic                boundary_c;

    assign value.value_ready = !pending_full && !rst;
    assign xfer_c            = value.value_valid && value.value_ready;

    display_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_c),
        .tc_c (tc_c)
    );

    // Next-state, double-buffer and output decode.
    always_comb begin
        state_nxt        = state;
        index_nxt        = index;
        pending_data_nxt = pending_data;
        pending_full_nxt = pending_full;
        display_nxt      = display_reg;
        boundary_c       = 1'b0;

        case (state)
            OFF: begin
                index_nxt = '0;
                if (scan_en) state_nxt = ON;
            end
            ON: begin
                if (!scan_en) begin
                    state_nxt = OFF;
                    index_nxt = '0;
                end else if (tc_c) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (!scan_en) begin
                    state_nxt = OFF;
                    index_nxt = '0;
                end else begin
                    state_nxt  = ON;
                    index_nxt  = index + IDX_W'(1);
                    boundary_c = (index == IDX_W'(DIGITS - 1));
                end
            end
            default: begin
                state_nxt = OFF;
                index_nxt = '0;
            end
        endcase

        // A load and a copy never coincide: loading needs pending empty, copying needs it full.
        if (xfer_c) begin
            pending_data_nxt = value.value_data;
            pending_full_nxt = 1'b1;
        end else if (boundary_c && pending_full) begin
            display_nxt      = pending_data;
            pending_full_nxt = 1'b0;
        end

        // Counter restarts at 0 on every entry into ON.
        cnt_clr_c = (state != ON) || (state_nxt != ON);

        digit_en_nxt     = (state_nxt == ON) ? digit_onehot(index_nxt) : '0;
        digit_nibble_nxt = (state_nxt == ON) ? display_nxt[{index_nxt, 2'b00} +: NIBBLE_W] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OFF;
            index        <= '0;
            pending_data <= '0;
            pending_full <= 1'b0;
            display_reg  <= '0;
            digit_en     <= '0;
            digit_nibble <= '0;
        end else begin
            state        <= state_nxt;
            index        <= index_nxt;
            pending_data <= pending_data_nxt;
            pending_full <= pending_full_nxt;
            display_reg  <= display_nxt;
            digit_en     <= digit_en_nxt;
            digit_nibble <= digit_nibble_nxt;
        end
    end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    logic digit_blank_nxt;

    // Blank lit digits above the most significant nonzero nibble; digit 0 always shows.
    always_comb begin
        digit_blank_nxt = (state_nxt == ON) && (index_nxt > top_nonzero_digit(display_nxt));
    end

    always_ff @(posedge clk) begin
        if (rst) digit_blank <= 1'b0;
        else     digit_blank <= digit_blank_nxt;
    end
`else
    assign digit_blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_4digit.sv
// Directed bench for display_scan_4digit at PRESCALE=3 (16-cycle frames).
module tb_display_scan_4digit;
    import display_pkg::*;

    localparam int unsigned P = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_en;
    logic [3:0] digit_nibble;
    logic [3:0] digit_en;
    logic       digit_blank;
    int         errors = 0;
    int         checks = 0;

    display_scan_4digit_if vif ();

    display_scan_4digit #(
        .PRESCALE (P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_en      (scan_en),
        .value        (vif),
        .digit_nibble (digit_nibble),
        .digit_en     (digit_en),
        .digit_blank  (digit_blank)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    function automatic int top_digit(input logic [15:0] v);
        for (int i = 3; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'h0) return i;
        end
        return 0;
    endfunction
`endif

    // Advance one cycle and check frame position c (0..15) against the shown value.
    task automatic scan_cycle(input string tag, input int c, input logic [15:0] shown,
                              input logic rdy);
        int         d;
        int         slot;
        logic       lit;
        logic [3:0] en_exp;
        logic       blank_exp;
        d    = c / 4;
        slot = c % 4;
        step;
        lit    = (slot < 3);
        en_exp = lit ? 4'(1 << d) : 4'b0000;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        blank_exp = lit && (d > top_digit(shown));
`else
        blank_exp = 1'b0;
`endif
        chk($sformatf("%s_c%0d_en", tag, c), 16'(digit_en), 16'(en_exp));
        if (lit) chk($sformatf("%s_c%0d_nib", tag, c), 16'(digit_nibble), 16'(shown[d*4 +: 4]));
        chk($sformatf("%s_c%0d_rdy", tag, c), 16'(vif.value_ready), 16'(rdy));
        chk($sformatf("%s_c%0d_blank", tag, c), 16'(digit_blank), 16'(blank_exp));
    endtask

    initial begin
        rst             = 1'b1;
        scan_en         = 1'b0;
        vif.value_valid = 1'b0;
        vif.value_data  = 16'h0000;
        step;
        step;
        chk("rst_en", 16'(digit_en), 16'h0);
        chk("rst_nib", 16'(digit_nibble), 16'h0);
        chk("rst_blank", 16'(digit_blank), 16'h0);
        chk("rst_rdy", 16'(vif.value_ready), 16'h0);

        rst = 1'b0;
        step;
        chk("post_rst_rdy", 16'(vif.value_ready), 16'h1);
        chk("off_en", 16'(digit_en), 16'h0);

        // Idle scan, nothing loaded.
        scan_en = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 16; c++) scan_cycle("idle", c, 16'h0000, 1'b1);
        scan_en = 1'b0;
        step;
        chk("idle_off_en", 16'(digit_en), 16'h0);
        chk("idle_off_nib", 16'(digit_nibble), 16'h0);

        // Load while dark; shown only after the first frame boundary.
        vif.value_valid = 1'b1;
        vif.value_data  = 16'hA5C3;
        step;
        vif.value_valid = 1'b0;
        chk("a5c3_pending_rdy", 16'(vif.value_ready), 16'h0);
        scan_en = 1'b1;
        for (int c = 0; c < 16; c++) scan_cycle("a5c3_f1", c, 16'h0000, 1'b0);
        for (int c = 0; c < 16; c++) scan_cycle("a5c3_f2", c, 16'hA5C3, 1'b1);

        // Back-pressure: 0x1111 loads, 0x2222 waits for the boundary.
        for (int c = 0; c < 16; c++) begin
            if (c == 1) begin
                vif.value_valid = 1'b1;
                vif.value_data  = 16'h1111;
            end
            if (c == 2) vif.value_data = 16'h2222;
            scan_cycle("bp_f3", c, 16'hA5C3, 1'(c == 0));
        end
        for (int c = 0; c < 16; c++) begin
            if (c == 2) vif.value_valid = 1'b0;
            scan_cycle("bp_f4", c, 16'h1111, 1'(c == 0));
        end
        for (int c = 0; c < 16; c++) scan_cycle("bp_f5", c, 16'h2222, 1'b1);

        // Load in the boundary cycle itself: held over one extra frame.
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                vif.value_valid = 1'b1;
                vif.value_data  = 16'h3456;
            end
            if (c == 1) vif.value_valid = 1'b0;
            scan_cycle("gap_f6", c, 16'h2222, 1'b0);
        end
        for (int c = 0; c < 16; c++) scan_cycle("gap_f7", c, 16'h3456, 1'b1);

        // Drop scan_en on digit 2, then restart from digit 0.
        for (int c = 0; c < 9; c++) scan_cycle("drop_f8", c, 16'h3456, 1'b1);
        scan_en = 1'b0;
        step;
        chk("drop_en", 16'(digit_en), 16'h0);
        chk("drop_nib", 16'(digit_nibble), 16'h0);
        step;
        chk("drop_en2", 16'(digit_en), 16'h0);
        scan_en = 1'b1;
        for (int c = 0; c < 16; c++) scan_cycle("reen_f9", c, 16'h3456, 1'b1);

        // Reset mid-frame with a pending value: both buffers cleared.
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                vif.value_valid = 1'b1;
                vif.value_data  = 16'hBEEF;
            end
            if (c == 4) vif.value_valid = 1'b0;
            scan_cycle("rst_f10", c, 16'h3456, 1'(c < 3));
        end
        rst = 1'b1;
        step;
        chk("midrst_en", 16'(digit_en), 16'h0);
        chk("midrst_nib", 16'(digit_nibble), 16'h0);
        chk("midrst_blank", 16'(digit_blank), 16'h0);
        chk("midrst_rdy", 16'(vif.value_ready), 16'h0);
        step;
        chk("midrst_en2", 16'(digit_en), 16'h0);
        rst = 1'b0;
        for (int c = 0; c < 16; c++) scan_cycle("post_rst_f11", c, 16'h0000, 1'b1);
        for (int c = 0; c < 16; c++) scan_cycle("post_rst_f12", c, 16'h0000, 1'b1);

        // Value with zero high nibbles.
        for (int c = 0; c < 16; c++) begin
            if (c == 1) begin
                vif.value_valid = 1'b1;
                vif.value_data  = 16'h0040;
            end
            if (c == 2) vif.value_valid = 1'b0;
            scan_cycle("lz_f13", c, 16'h0000, 1'(c == 0));
        end
        for (int c = 0; c < 16; c++) scan_cycle("lz_f14", c, 16'h0040, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
